// File: rtl/ball_handoff_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ball_handoff_sequencer_if
// Purpose  : Register-write handshake between the ball handoff sequencer and
//            the I2C master that carries the writes to the peer board.
// Signals  : i2c_req       sequencer -> master, 1-cycle write request
//            i2c_reg_addr  sequencer -> master, peer register index 0..5
//            i2c_wdata     sequencer -> master, write data
//            i2c_busy      master -> sequencer, master cannot accept a request
//            i2c_done      master -> sequencer, 1-cycle transaction-end pulse
//            i2c_ack_ok    master -> sequencer, 1 = ACKed (valid with done)
// Modports : master = sequencer side (issues requests)
//            slave  = I2C master side (serves requests)
// Revision : 1.0  initial release
// ============================================================================
interface ball_handoff_sequencer_if;
  logic       i2c_req;
  logic [2:0] i2c_reg_addr;
  logic [7:0] i2c_wdata;
  logic       i2c_busy;
  logic       i2c_done;
  logic       i2c_ack_ok;

  modport master (
    output i2c_req, i2c_reg_addr, i2c_wdata,
    input  i2c_busy, i2c_done, i2c_ack_ok
  );

  modport slave (
    input  i2c_req, i2c_reg_addr, i2c_wdata,
    output i2c_busy, i2c_done, i2c_ack_ok
  );
endinterface
`default_nettype wire

// File: rtl/ball_handoff_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ball_handoff_sequencer
// Purpose  : On a rising edge of ball_send_trigger, snapshot the ball state
//            and write it to peer registers 0..4 followed by a GO write to
//            register 5, one I2C transaction at a time, with per-register
//            retry on NACK or timeout.
// Ports    : clk_25MHZ, reset (async, active-high)
//            ball_send_trigger, ball_y_in[9:0], ball_vy_in[7:0],
//            gravity_in[1:0], speed_code_in[7:0]   - game inputs
//            i2c (master modport)                   - write handshake
//            xfer_busy, xfer_done (pulse), xfer_error (sticky),
//            fail_count[7:0] (saturating)          - status
// Revision : 1.0  initial release
// ============================================================================
module ball_handoff_sequencer #(
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 250000,
  parameter int BACKOFF_CYC = 2500
) (
  input  wire logic                clk_25MHZ,
  input  wire logic                reset,
  input  wire logic                ball_send_trigger,
  input  wire logic [9:0]          ball_y_in,
  input  wire logic [7:0]          ball_vy_in,
  input  wire logic [1:0]          gravity_in,
  input  wire logic [7:0]          speed_code_in,
  ball_handoff_sequencer_if.master i2c,
  output logic                     xfer_busy,
  output logic                     xfer_done,
  output logic                     xfer_error,
  output logic [7:0]               fail_count
);

  localparam int c_CNT_MAX   = (TIMEOUT_CYC > BACKOFF_CYC) ? TIMEOUT_CYC : BACKOFF_CYC;
  localparam int c_CNT_W     = $clog2(c_CNT_MAX + 1);
  localparam int c_RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [2:0] c_LAST_REG = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LATCH     = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_BACKOFF   = 3'd4,
    S_DONE      = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_trig_d;
  logic [9:0]             r_y;
  logic [7:0]             r_vy;
  logic [1:0]             r_grav;
  logic [7:0]             r_speed;
  logic [2:0]             r_reg_idx;
  logic [c_RETRY_W-1:0]   r_retry;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [2:0]             r_addr;
  logic [7:0]             r_wdata;
  logic                   r_error;
  logic [7:0]             r_fail_count;

  logic                   w_start;
  logic                   w_issue;
  logic                   w_advance;
  logic                   w_fail;
  logic [7:0]             w_wdata;

  // Register map, always taken from the snapshot, never the live inputs.
  always_comb begin
    w_wdata = 8'h01;
    case (r_reg_idx)
      3'd0:    w_wdata = {r_y[9:8], 6'b0};
      3'd1:    w_wdata = r_y[7:0];
      3'd2:    w_wdata = r_vy;
      3'd3:    w_wdata = {6'b0, r_grav};
      3'd4:    w_wdata = r_speed;
      default: w_wdata = 8'h01;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = ball_send_trigger & ~r_trig_d;
    w_issue     = 1'b0;
    w_advance   = 1'b0;
    w_fail      = 1'b0;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (!i2c.i2c_busy) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // A done pulse on the final timeout cycle still counts as a response.
        if (i2c.i2c_done) begin
          if (i2c.i2c_ack_ok) begin
            if (r_reg_idx == c_LAST_REG) begin
              w_state_nxt = S_DONE;
            end else begin
              w_advance   = 1'b1;
              w_state_nxt = S_ISSUE;
            end
          end else begin
            w_fail = 1'b1;
          end
        end else if (r_cnt == c_CNT_W'(TIMEOUT_CYC - 1)) begin
          w_fail = 1'b1;
        end
        if (w_fail) begin
          w_state_nxt = (r_retry == c_RETRY_W'(MAX_RETRY)) ? S_ERROR : S_BACKOFF;
        end
      end
      S_BACKOFF: if (r_cnt == c_CNT_W'(BACKOFF_CYC - 1)) w_state_nxt = S_ISSUE;
      S_DONE:    w_state_nxt = S_IDLE;
      S_ERROR:   w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_trig_d     <= 1'b0;
      r_y          <= '0;
      r_vy         <= '0;
      r_grav       <= '0;
      r_speed      <= '0;
      r_reg_idx    <= '0;
      r_retry      <= '0;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_error      <= 1'b0;
      r_fail_count <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_trig_d <= ball_send_trigger;

      if (r_state == S_LATCH) begin
        r_y     <= ball_y_in;
        r_vy    <= ball_vy_in;
        r_grav  <= gravity_in;
        r_speed <= speed_code_in;
      end

      if (w_state_nxt == S_LATCH) begin
        r_reg_idx <= '0;
        r_retry   <= '0;
        r_error   <= 1'b0;
      end

      if (w_advance) begin
        r_reg_idx <= r_reg_idx + 3'd1;
        r_retry   <= '0;
      end

      if (w_fail) begin
        if (r_fail_count != 8'hFF) r_fail_count <= r_fail_count + 8'd1;
        if (r_retry != c_RETRY_W'(MAX_RETRY)) r_retry <= r_retry + 1'b1;
      end

      if (w_state_nxt == S_ERROR) r_error <= 1'b1;

      // Address/data are held between requests so the master can re-read them.
      if (w_issue) begin
        r_addr  <= r_reg_idx;
        r_wdata <= w_wdata;
      end

      // One counter serves both the response timeout and the retry backoff;
      // it restarts on every state change.
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT_DONE || r_state == S_BACKOFF) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    i2c.i2c_req      = w_issue;
    i2c.i2c_reg_addr = w_issue ? r_reg_idx : r_addr;
    i2c.i2c_wdata    = w_issue ? w_wdata : r_wdata;
  end

  assign xfer_busy  = (r_state == S_LATCH) || (r_state == S_ISSUE) ||
                      (r_state == S_WAIT_DONE) || (r_state == S_BACKOFF);
  assign xfer_done  = (r_state == S_DONE);
  assign xfer_error = r_error;
  assign fail_count = r_fail_count;

endmodule
`default_nettype wire

// File: tb/tb_ball_handoff_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ball_handoff_sequencer
// Purpose  : Directed self-checking bench for ball_handoff_sequencer with a
//            scripted I2C master model (ACK / NACK / silent per register).
// Revision : 1.0  initial release
// ============================================================================
module tb_ball_handoff_sequencer;
  localparam int c_TO = 40;
  localparam int c_BO = 10;
  localparam int c_MR = 3;

  logic       clk_25MHZ = 1'b0;
  logic       reset = 1'b1;
  logic       trig = 1'b0;
  logic [9:0] y = '0;
  logic [7:0] vy = '0;
  logic [1:0] grav = '0;
  logic [7:0] speed = '0;
  logic       xfer_busy, xfer_done, xfer_error;
  logic [7:0] fail_count;

  ball_handoff_sequencer_if bus();

  ball_handoff_sequencer #(
    .MAX_RETRY(c_MR), .TIMEOUT_CYC(c_TO), .BACKOFF_CYC(c_BO)
  ) dut (
    .clk_25MHZ        (clk_25MHZ),
    .reset            (reset),
    .ball_send_trigger(trig),
    .ball_y_in        (y),
    .ball_vy_in       (vy),
    .gravity_in       (grav),
    .speed_code_in    (speed),
    .i2c              (bus),
    .xfer_busy        (xfer_busy),
    .xfer_done        (xfer_done),
    .xfer_error       (xfer_error),
    .fail_count       (fail_count)
  );

  always #20 clk_25MHZ = ~clk_25MHZ;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk_25MHZ) cyc++;

  // I2C master model: answers one cycle after the request unless told to
  // stay silent for a register or to NACK it a number of times.
  int   nack_reg = -1, nack_left = 0, silent_reg = -1;
  logic pend = 1'b0, pend_ack = 1'b0, err_d = 1'b0;
  int   log_cyc[$], log_addr[$], log_data[$];
  int   done_cnt = 0, done_cyc = 0, err_cyc = 0;

  initial begin
    bus.i2c_busy   = 1'b0;
    bus.i2c_done   = 1'b0;
    bus.i2c_ack_ok = 1'b0;
  end

  always @(negedge clk_25MHZ) begin
    #5;
    bus.i2c_done   = 1'b0;
    bus.i2c_ack_ok = 1'b0;
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        bus.i2c_done   = 1'b1;
        bus.i2c_ack_ok = pend_ack;
        pend = 1'b0;
      end
      if (bus.i2c_req === 1'b1) begin
        log_cyc.push_back(cyc);
        log_addr.push_back(int'(bus.i2c_reg_addr));
        log_data.push_back(int'(bus.i2c_wdata));
        if (int'(bus.i2c_reg_addr) != silent_reg) begin
          pend = 1'b1;
          pend_ack = 1'b1;
          if (int'(bus.i2c_reg_addr) == nack_reg && nack_left > 0) begin
            pend_ack = 1'b0;
            nack_left--;
          end
        end
      end
      if (xfer_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (xfer_error === 1'b1 && err_d !== 1'b1) err_cyc = cyc;
    end
    err_d = xfer_error;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance until the transfer leaves its busy states, then one more cycle
  // so the model has logged the final status.
  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    repeat (2) @(negedge clk_25MHZ);
    while (xfer_busy === 1'b1 && n < budget) begin
      @(negedge clk_25MHZ);
      n++;
    end
    chk("idle_within_budget", {31'b0, xfer_busy}, 32'd0);
    @(negedge clk_25MHZ);
  endtask

  int t0, t1, base, dbase;
  logic [7:0] exp1 [6];

  initial begin
    exp1 = '{8'h80, 8'hA5, 8'hFD, 8'h02, 8'h40, 8'h01};

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk_25MHZ);
    #1;
    chk("rst_req",   {31'b0, bus.i2c_req}, 0);
    chk("rst_addr",  {29'b0, bus.i2c_reg_addr}, 0);
    chk("rst_wdata", {24'b0, bus.i2c_wdata}, 0);
    chk("rst_busy",  {31'b0, xfer_busy}, 0);
    chk("rst_done",  {31'b0, xfer_done}, 0);
    chk("rst_error", {31'b0, xfer_error}, 0);
    chk("rst_fails", {24'b0, fail_count}, 0);
    @(negedge clk_25MHZ);
    reset = 1'b0;
    repeat (2) @(negedge clk_25MHZ);

    // ---------------- 1: happy path ----------------
    y = 10'h2A5; vy = 8'hFD; grav = 2'd2; speed = 8'h40;
    base = log_addr.size(); dbase = done_cnt;
    trig = 1'b1; t0 = cyc;
    run_until_idle(200);
    chk("t1_nwrites", log_addr.size() - base, 6);
    for (int k = 0; k < 6; k++) begin
      if (base + k < log_addr.size()) begin
        chk($sformatf("t1_addr%0d", k), log_addr[base + k], k);
        chk($sformatf("t1_data%0d", k), log_data[base + k], {24'b0, exp1[k]});
        chk($sformatf("t1_cyc%0d", k), log_cyc[base + k] - t0, 2 + 2 * k);
      end
    end
    chk("t1_done_cnt", done_cnt - dbase, 1);
    chk("t1_latency", done_cyc - t0, 14);
    chk("t1_error", {31'b0, xfer_error}, 0);
    chk("t1_fails", {24'b0, fail_count}, 0);
    trig = 1'b0;
    repeat (3) @(negedge clk_25MHZ);

    // ---------------- 2: two NACKs on reg2 ----------------
    y = 10'h155; vy = 8'h05; grav = 2'd1; speed = 8'h22;
    nack_reg = 2; nack_left = 2;
    base = log_addr.size(); dbase = done_cnt;
    trig = 1'b1; t0 = cyc;
    run_until_idle(300);
    chk("t2_nwrites", log_addr.size() - base, 8);
    if (log_addr.size() >= base + 8) begin
      for (int k = 2; k < 5; k++) begin
        chk($sformatf("t2_addr%0d", k), log_addr[base + k], 2);
        chk($sformatf("t2_data%0d", k), log_data[base + k], 32'h05);
      end
      chk("t2_first_reg2", log_cyc[base + 2] - t0, 6);
      chk("t2_retry_gap1", log_cyc[base + 3] - log_cyc[base + 2], c_BO + 2);
      chk("t2_retry_gap2", log_cyc[base + 4] - log_cyc[base + 3], c_BO + 2);
      chk("t2_reg0_data", log_data[base], 32'h40);
      chk("t2_go", log_data[base + 7], 32'h01);
    end
    chk("t2_fails", {24'b0, fail_count}, 2);
    chk("t2_done_cnt", done_cnt - dbase, 1);
    chk("t2_latency", done_cyc - t0, 14 + 2 * (c_BO + 2));
    chk("t2_error", {31'b0, xfer_error}, 0);
    trig = 1'b0; nack_reg = -1;
    repeat (3) @(negedge clk_25MHZ);

    // ---------------- 3: reg3 never answers ----------------
    silent_reg = 3;
    base = log_addr.size(); dbase = done_cnt;
    trig = 1'b1; t0 = cyc;
    run_until_idle(400);
    chk("t3_nwrites", log_addr.size() - base, 7);
    if (log_addr.size() >= base + 7) begin
      chk("t3_first_reg3", log_cyc[base + 3] - t0, 8);
      for (int k = 3; k < 7; k++) chk($sformatf("t3_addr%0d", k), log_addr[base + k], 3);
      for (int k = 4; k < 7; k++)
        chk($sformatf("t3_gap%0d", k), log_cyc[base + k] - log_cyc[base + k - 1], c_TO + c_BO + 1);
    end
    chk("t3_error", {31'b0, xfer_error}, 1);
    chk("t3_busy", {31'b0, xfer_busy}, 0);
    chk("t3_no_done", done_cnt - dbase, 0);
    chk("t3_fails", {24'b0, fail_count}, 6);
    chk("t3_err_time", err_cyc - t0, 8 + 3 * (c_TO + c_BO + 1) + c_TO + 1);
    repeat (5) @(negedge clk_25MHZ);
    chk("t3_error_sticky", {31'b0, xfer_error}, 1);
    trig = 1'b0; silent_reg = -1;
    repeat (3) @(negedge clk_25MHZ);

    // ---------------- 4: busy held at ISSUE ----------------
    base = log_addr.size(); dbase = done_cnt;
    bus.i2c_busy = 1'b1;
    trig = 1'b1; t0 = cyc;
    repeat (50) @(negedge clk_25MHZ);
    chk("t4_no_req", log_addr.size() - base, 0);
    chk("t4_busy", {31'b0, xfer_busy}, 1);
    chk("t4_error_clr", {31'b0, xfer_error}, 0);
    bus.i2c_busy = 1'b0; t1 = cyc;
    run_until_idle(200);
    chk("t4_nwrites", log_addr.size() - base, 6);
    if (log_addr.size() > base) chk("t4_first_req", log_cyc[base] - t1, 0);
    chk("t4_latency", done_cyc - t1, 12);
    chk("t4_done_cnt", done_cnt - dbase, 1);
    trig = 1'b0;
    repeat (3) @(negedge clk_25MHZ);

    // ---------------- 5: trigger held, inputs change ----------------
    y = 10'h3C7; vy = 8'h80; grav = 2'd3; speed = 8'hFF;
    base = log_addr.size(); dbase = done_cnt;
    trig = 1'b1; t0 = cyc;
    repeat (2) @(negedge clk_25MHZ);
    y = 10'h000; vy = 8'h11; grav = 2'd0; speed = 8'h33;
    repeat (998) @(negedge clk_25MHZ);
    chk("t5_nwrites", log_addr.size() - base, 6);
    chk("t5_done_cnt", done_cnt - dbase, 1);
    if (log_addr.size() >= base + 6) begin
      chk("t5_d0", log_data[base],     32'hC0);
      chk("t5_d1", log_data[base + 1], 32'hC7);
      chk("t5_d2", log_data[base + 2], 32'h80);
      chk("t5_d3", log_data[base + 3], 32'h03);
      chk("t5_d4", log_data[base + 4], 32'hFF);
    end
    trig = 1'b0;
    repeat (3) @(negedge clk_25MHZ);

    // ---------------- 6: reset during reg3 wait ----------------
    silent_reg = 3;
    base = log_addr.size(); dbase = done_cnt;
    trig = 1'b1;
    for (int n = 0; n < 100 && log_addr.size() < base + 4; n++) @(negedge clk_25MHZ);
    chk("t6_reached_reg3", log_addr.size() - base, 4);
    repeat (5) @(negedge clk_25MHZ);
    reset = 1'b1; trig = 1'b0;
    #1;
    chk("t6_req",   {31'b0, bus.i2c_req}, 0);
    chk("t6_addr",  {29'b0, bus.i2c_reg_addr}, 0);
    chk("t6_wdata", {24'b0, bus.i2c_wdata}, 0);
    chk("t6_busy",  {31'b0, xfer_busy}, 0);
    chk("t6_fails", {24'b0, fail_count}, 0);
    repeat (2) @(negedge clk_25MHZ);
    reset = 1'b0; silent_reg = -1;
    repeat (2) @(negedge clk_25MHZ);
    chk("t6_no_partial_done", done_cnt - dbase, 0);
    y = 10'h2A5; vy = 8'hFD; grav = 2'd2; speed = 8'h40;
    base = log_addr.size();
    trig = 1'b1; t0 = cyc;
    run_until_idle(200);
    chk("t6_nwrites", log_addr.size() - base, 6);
    if (log_addr.size() > base) begin
      chk("t6_restart_addr", log_addr[base], 0);
      chk("t6_restart_data", log_data[base], 32'h80);
    end
    chk("t6_done_cnt", done_cnt - dbase, 1);
    chk("t6_latency", done_cyc - t0, 14);
    chk("t6_error", {31'b0, xfer_error}, 0);
    trig = 1'b0;
    repeat (3) @(negedge clk_25MHZ);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(40 * 50000);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
